// File: rtl/addsub_arbiter.sv
// Two-requester round-robin front end for a shared scaled fixed-point add/sub datapath.
// One operation occupies IDLE->EXEC->DONE; the result is captured from the datapath at the end of EXEC.
module addsub_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             sub0,
  input  logic             sub1,
  input  logic [15:0]      a0,
  input  logic [15:0]      b0,
  input  logic [15:0]      a1,
  input  logic [15:0]      b1,
  output logic             ack0,
  output logic             ack1,
  output logic             done0,
  output logic             done1,
  output logic [15:0]      result,
  output logic             result_invalid,
  output logic             dp_enable,
  output logic             dp_sub,
  output logic             dp_cin,
  output logic [15:0]      dp_in1,
  output logic [15:0]      dp_in2,
  input  logic [15:0]      dp_out,
  input  logic             dp_cout,
  input  logic             dp_invalid,
  output logic             busy,
  output logic [CNT_W-1:0] err_count
);

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t            state, state_nxt;
  logic              ptr;
  logic              grant, grant_nxt;
  logic              take;
  logic              sub_p0;
  logic [DATA_W-1:0] a_p0, b_p0;
  logic              unused_cout;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_W'(1);
  endfunction

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    take      = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          take      = 1'b1;
          state_nxt = EXEC;
          // Only a genuine conflict consults the pointer; a lone request wins outright.
          grant_nxt = (req0 && req1) ? ptr : req1;
        end
      end
      EXEC:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      grant          <= 1'b0;
      ptr            <= 1'b0;
      err_count      <= '0;
      result         <= '0;
      result_invalid <= 1'b0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      if (state == DONE) ptr <= ~grant;
      if (state == EXEC) begin
        result         <= dp_out;
        result_invalid <= dp_invalid;
        if (dp_invalid) err_count <= sat_inc(err_count);
      end
    end
  end

  // ---- stage p0: operands of the granted requester, held through EXEC ----
  always_ff @(posedge clk) begin
    if (take) begin
      sub_p0 <= grant_nxt ? sub1 : sub0;
      a_p0   <= grant_nxt ? a1   : a0;
      b_p0   <= grant_nxt ? b1   : b0;
    end
    if (state == EXEC) unused_cout <= dp_cout;
  end

  // ---- datapath drive and handshake outputs, decoded from state ----
  always_comb begin
    dp_enable = (state == EXEC);
    dp_sub    = (state == EXEC) ? sub_p0 : 1'b0;
    dp_in1    = (state == EXEC) ? a_p0   : '0;
    dp_in2    = (state == EXEC) ? b_p0   : '0;
    dp_cin    = 1'b0;
    ack0      = (state == EXEC) && !grant;
    ack1      = (state == EXEC) &&  grant;
    done0     = (state == DONE) && !grant;
    done1     = (state == DONE) &&  grant;
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: vector table, directed corner sequences and a
// randomized run against a phase-level reference model. The bench also plays the datapath.
module tb_addsub_arbiter;
  localparam int CNT_W = 8;
  localparam int ERR_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, req0, req1, sub0, sub1;
  logic [15:0] a0, b0, a1, b1;
  logic ack0, ack1, done0, done1, result_invalid;
  logic [15:0] result;
  logic dp_enable, dp_sub, dp_cin, dp_cout, dp_invalid, busy;
  logic [15:0] dp_in1, dp_in2, dp_out;
  logic [CNT_W-1:0] err_count;
  logic [16:0] wide_sum;
  logic inv;

  addsub_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .sub0(sub0), .sub1(sub1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .ack0(ack0), .ack1(ack1), .done0(done0),
    .done1(done1), .result(result), .result_invalid(result_invalid),
    .dp_enable(dp_enable), .dp_sub(dp_sub), .dp_cin(dp_cin), .dp_in1(dp_in1),
    .dp_in2(dp_in2), .dp_out(dp_out), .dp_cout(dp_cout), .dp_invalid(dp_invalid),
    .busy(busy), .err_count(err_count)
  );

  // Bench datapath: plain 16-bit add/subtract, invalid flag driven by the bench.
  assign dp_out     = dp_sub ? dp_in1 - dp_in2 : dp_in1 + dp_in2;
  assign wide_sum   = {1'b0, dp_in1} + {1'b0, dp_in2};
  assign dp_cout    = dp_sub ? 1'b0 : wide_sum[16];
  assign dp_invalid = inv;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        inv;
    logic [15:0] res;
  } vec_t;
  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // One complete single-requester transaction with checks in every phase.
  task automatic op(input int r, input logic s, input logic [15:0] a, input logic [15:0] b,
                    input logic iv, input logic [15:0] exp_res, input string tag);
    if (r == 0) begin req0 = 1'b1; sub0 = s; a0 = a; b0 = b; end
    else        begin req1 = 1'b1; sub1 = s; a1 = a; b1 = b; end
    inv = iv;
    step();
    chk({tag, " ack0"}, 32'(ack0), 32'(r == 0));
    chk({tag, " ack1"}, 32'(ack1), 32'(r == 1));
    chk({tag, " dp_enable"}, 32'(dp_enable), 32'd1);
    chk({tag, " dp_in1"}, 32'(dp_in1), 32'(a));
    chk({tag, " dp_in2"}, 32'(dp_in2), 32'(b));
    chk({tag, " dp_sub"}, 32'(dp_sub), 32'(s));
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    chk({tag, " done0"}, 32'(done0), 32'(r == 0));
    chk({tag, " done1"}, 32'(done1), 32'(r == 1));
    chk({tag, " result"}, 32'(result), 32'(exp_res));
    chk({tag, " result_invalid"}, 32'(result_invalid), 32'(iv));
    chk({tag, " dp_enable in done"}, 32'(dp_enable), 32'd0);
    inv = 1'b0;
    step();
    chk({tag, " busy after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int exp_err;
    int grants[$];
    int ph;
    logic m_ptr, m_g, m_sub, m_inv;
    logic [15:0] m_a, m_b, m_res;
    int m_err;
    logic [15:0] ra, rb, rexp;

    vecs[0] = '{1'b0, 16'h0003, 16'h0005, 1'b0, 16'h0008};
    vecs[1] = '{1'b1, 16'h0005, 16'h0003, 1'b0, 16'h0002};
    vecs[2] = '{1'b1, 16'h0003, 16'h0005, 1'b1, 16'hFFFE};
    vecs[3] = '{1'b0, 16'h7FFF, 16'h0001, 1'b1, 16'h8000};
    vecs[4] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000};
    vecs[5] = '{1'b1, 16'h2000, 16'hE123, 1'b0, 16'h3EDD};

    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; sub0 = 1'b0; sub1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; inv = 1'b0;
    step();
    step();
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset acks", 32'({ack0, ack1}), 32'd0);
    chk("reset dones", 32'({done0, done1}), 32'd0);
    chk("reset dp ctl", 32'({dp_enable, dp_sub, dp_cin}), 32'd0);
    chk("reset dp_in", 32'({dp_in1, dp_in2}), 32'd0);
    chk("reset result", 32'(result), 32'd0);
    chk("reset result_invalid", 32'(result_invalid), 32'd0);
    chk("reset err_count", 32'(err_count), 32'd0);
    reset = 1'b0;

    // Reset landing on the EXEC cycle aborts the operation.
    req0 = 1'b1; a0 = 16'h0003; b0 = 16'h0005; inv = 1'b1;
    step();
    chk("abort ack0", 32'(ack0), 32'd1);
    req0 = 1'b0;
    pulse_reset();
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done0", 32'(done0), 32'd0);
    chk("abort err_count", 32'(err_count), 32'd0);
    chk("abort result", 32'(result), 32'd0);
    step();
    chk("abort no late done", 32'({done0, done1}), 32'd0);
    inv = 1'b0;

    // Vector table, alternating requesters.
    exp_err = 0;
    for (int i = 0; i < 6; i++) begin
      op(i % 2, vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].inv, vecs[i].res,
         $sformatf("vec%0d", i));
      if (vecs[i].inv) exp_err++;
      chk($sformatf("vec%0d err_count", i), 32'(err_count), 32'(exp_err));
    end

    // Simultaneous requests with pointer at 0: requester 0 first, requester 1 three cycles later.
    pulse_reset();
    req0 = 1'b1; req1 = 1'b1; a0 = 16'h0001; b0 = 16'h0002; sub0 = 1'b0;
    a1 = 16'h000A; b1 = 16'h0004; sub1 = 1'b1;
    step();
    chk("both ack0 first", 32'({ack0, ack1}), 32'b10);
    req0 = 1'b0;
    step();
    chk("both done0", 32'({done0, done1}), 32'b10);
    chk("both result0", 32'(result), 32'h0003);
    step();
    chk("both no sample in done", 32'({ack1, busy}), 32'd0);
    step();
    chk("both ack1 +3", 32'({ack0, ack1}), 32'b01);
    req1 = 1'b0;
    step();
    chk("both done1", 32'({done0, done1}), 32'b01);
    chk("both result1", 32'(result), 32'h0006);
    step();

    // Both held for four operations: grants alternate, never two acks or dones together.
    pulse_reset();
    req0 = 1'b1; req1 = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      chk("rr ack onehot", 32'(ack0 & ack1), 32'd0);
      chk("rr done onehot", 32'(done0 & done1), 32'd0);
      if (ack0 || ack1) grants.push_back(ack1 ? 1 : 0);
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("rr grant count", 32'(grants.size()), 32'd4);
    for (int k = 0; k < grants.size(); k++)
      chk($sformatf("rr grant%0d", k), 32'(grants[k]), 32'(k % 2));
    step();
    step();

    // A short req1 pulse while busy is never served.
    req0 = 1'b1; a0 = 16'h0010; b0 = 16'h0001;
    step();
    req0 = 1'b0; req1 = 1'b1;
    step();
    req1 = 1'b0;
    chk("pulse done0", 32'(done0), 32'd1);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("pulse no ack1", 32'(ack1), 32'd0);
      chk("pulse idle", 32'(busy), 32'd0);
    end

    // 300 invalid operations: counter saturates.
    pulse_reset();
    inv = 1'b1;
    for (int k = 0; k < 300; k++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      req0 = 1'b1; a0 = ra; b0 = rb; sub0 = k[0];
      rexp = k[0] ? ra - rb : ra + rb;
      step();
      req0 = 1'b0;
      step();
      chk("sat done0", 32'(done0), 32'd1);
      chk("sat result", 32'(result), 32'(rexp));
      chk("sat result_invalid", 32'(result_invalid), 32'd1);
      chk("sat err_count", 32'(err_count), 32'((k + 1 > ERR_MAX) ? ERR_MAX : k + 1));
      step();
    end
    inv = 1'b0;
    chk("sat final err_count", 32'(err_count), 32'd255);

    // Randomized traffic against a phase-level model (0 idle, 1 exec, 2 done).
    pulse_reset();
    ph = 0; m_ptr = 1'b0; m_g = 1'b0; m_err = 0;
    m_sub = 1'b0; m_a = '0; m_b = '0; m_res = '0; m_inv = 1'b0;
    for (int c = 0; c < 400; c++) begin
      req0 = 1'($urandom_range(0, 1)); req1 = 1'($urandom_range(0, 1));
      sub0 = 1'($urandom_range(0, 1)); sub1 = 1'($urandom_range(0, 1));
      a0 = 16'($urandom); b0 = 16'($urandom); a1 = 16'($urandom); b1 = 16'($urandom);
      inv = 1'($urandom_range(0, 1));
      if (ph == 0) begin
        if (req0 || req1) begin
          m_g = (req0 && req1) ? m_ptr : req1;
          m_sub = m_g ? sub1 : sub0;
          m_a = m_g ? a1 : a0;
          m_b = m_g ? b1 : b0;
          ph = 1;
        end
      end else if (ph == 1) begin
        m_res = m_sub ? m_a - m_b : m_a + m_b;
        m_inv = inv;
        if (inv && m_err < ERR_MAX) m_err++;
        ph = 2;
      end else begin
        m_ptr = !m_g;
        ph = 0;
      end
      step();
      chk("rnd ack0", 32'(ack0), 32'(ph == 1 && !m_g));
      chk("rnd ack1", 32'(ack1), 32'(ph == 1 && m_g));
      chk("rnd done0", 32'(done0), 32'(ph == 2 && !m_g));
      chk("rnd done1", 32'(done1), 32'(ph == 2 && m_g));
      chk("rnd busy", 32'(busy), 32'(ph != 0));
      chk("rnd dp_enable", 32'(dp_enable), 32'(ph == 1));
      if (ph == 1)
        chk("rnd dp operands", 32'({dp_in1, dp_in2}), {m_a, m_b});
      if (ph == 2) begin
        chk("rnd result", 32'(result), 32'(m_res));
        chk("rnd result_invalid", 32'(result_invalid), 32'(m_inv));
      end
      chk("rnd err_count", 32'(err_count), 32'(m_err));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 Parameter: CNT_W, default 8, width of the saturating invalid-result counter.
REQ-002 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge system clock.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 req0, req1  in  1 each  operation request from requester 0 and requester 1.
REQ-006 sub0, sub1  in  1 each  per-requester operation select: 0 = add, 1 = subtract.
REQ-007 a0, b0, a1, b1  in  16 each  per-requester operands in the scaled fixed-point format: [15:13] scale, [12:0] signed mantissa.
REQ-008 ack0, ack1  out  1 each  one-cycle acceptance pulse to the granted requester.
REQ-009 done0, done1  out  1 each  one-cycle result-valid pulse to the granted requester.
REQ-010 result  out  16  shared result bus, valid only while done0 or done1 is high.
REQ-011 result_invalid  out  1  overflow/invalid flag accompanying result.
REQ-012 dp_enable, dp_sub, dp_cin  out  1 each  controls to the shared add/sub datapath.
REQ-013 dp_in1, dp_in2  out  16 each  operands to the datapath.
REQ-014 dp_out  in  16  datapath result, combinational from the dp_* outputs.
REQ-015 dp_cout, dp_invalid  in  1 each  datapath carry-out and invalid flag.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 err_count  out  CNT_W  saturating count of operations completed with dp_invalid=1.

Function
REQ-018 FSM states are IDLE, EXEC and DONE; state, grant and operand registers are updated only on rising clk edges.
REQ-019 IDLE: on an edge with any reqN=1, the block latches the grant, subN, aN and bN, then enters EXEC; with no request it stays in IDLE.
REQ-020 Arbitration is round-robin with a 1-bit priority pointer, reset value 0 (requester 0 first).
- When both requests are high, the pointed-to requester wins.
- The pointer moves to the other requester on the DONE->IDLE transition.
REQ-021 EXEC lasts exactly one cycle.
- Asserts ackN for the granted requester.
- Drives dp_enable=1, dp_in1/dp_in2/dp_sub from the latched values, dp_cin=0.
- On the closing edge, dp_out and dp_invalid are captured into result and result_invalid, and the FSM enters DONE.
REQ-022 DONE lasts exactly one cycle.
- Asserts doneN for the granted requester, with result and result_invalid held.
- Then returns to IDLE unconditionally.
REQ-023 Latency: a request sampled at edge k gives ack during cycle k..k+1 and done during cycle k+1..k+2; throughput is one operation per 3 cycles.
REQ-024 Outside EXEC, dp_enable=0 and dp_in1, dp_in2, dp_sub and dp_cin are 0.
REQ-025 Outside DONE, done0 and done1 are 0; result and result_invalid keep their last captured value.
REQ-026 Requests are level-sensitive and must be held until ack.
- A request deasserted before it is granted is dropped silently.
- A request held during EXEC or DONE is not sampled until the FSM is back in IDLE.
- A requester holding req after its done is served again, subject to round-robin.
REQ-027 At most one ackN and at most one doneN are high in any cycle.
REQ-028 err_count increments by 1 on the EXEC->DONE edge when dp_invalid=1, and saturates at 2^CNT_W-1.
REQ-029 dp_cout is captured but not used; it has no effect on any output.

Reset
REQ-030 When reset=1 at an edge:
- state becomes IDLE, priority pointer 0, err_count 0, result 16'h0000, result_invalid 0.
- all ack, done, busy and dp_* outputs are 0 in the following cycle.
REQ-031 Reset during EXEC or DONE aborts the operation: no done pulse is issued and err_count is not incremented.
REQ-032 Reset has priority over any simultaneous request.

Verification (bench datapath model: dp_out = dp_in1 ± dp_in2 per dp_sub; dp_invalid driven by the bench)
REQ-033 req0=1, a0=16'h0003, b0=16'h0005, sub0=0 -> ack0 one cycle after the sampling edge, then done0 with result=16'h0008, result_invalid=0.
REQ-034 req0 and req1 high in the same cycle, pointer 0 -> requester 0 served first (done0), then requester 1 (done1), with ack1 exactly 3 cycles after ack0.
REQ-035 Both requests held continuously for 4 operations -> grants alternate 0,1,0,1; no cycle has both acks or both dones high.
REQ-036 Bench forces dp_invalid=1 for 300 consecutive operations with CNT_W=8 -> result_invalid=1 on each done; err_count stops at 255.
REQ-037 reset asserted during the EXEC cycle -> no done pulse; next cycle busy=0, err_count unchanged at 0, result=16'h0000.
REQ-038 req1 pulsed for one cycle while busy=1 and low again before IDLE -> never acked; the FSM stays in IDLE.
